// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared types and constants for the bit-serial adder receive end.
//   - serial_add_state_e : FSM state encoding (IDLE, SHIFT, DONE)
//   - SERIAL_ADD_WIDTH   : default operand/sum width
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int SERIAL_ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_add_state_e;

endpackage : serial_add_pkg

// File: rtl/full_add_cell.sv
// -----------------------------------------------------------------------------
// full_add_cell
// One-bit full adder built from two half-adder stages and an OR of their
// carries.
//   a, b  : input  operand bits
//   cin   : input  carry in
//   s     : output sum bit
//   cout  : output carry out
// -----------------------------------------------------------------------------
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_sum_s;
    logic ha0_cy_s;
    logic ha1_cy_s;

    // First half adder: a + b
    assign ha0_sum_s = a ^ b;
    assign ha0_cy_s  = a & b;

    // Second half adder: partial sum + carry in
    assign s         = ha0_sum_s ^ cin;
    assign ha1_cy_s  = ha0_sum_s & cin;

    // At most one half adder can produce a carry, so OR merges them
    assign cout      = ha0_cy_s | ha1_cy_s;

endmodule : full_add_cell

// File: rtl/serial_add_rx.sv
// -----------------------------------------------------------------------------
// serial_add_rx
// Bit-serial adder receive end. Accepts operand bit pairs LSB-first over a
// bit_valid/bit_ready handshake, adds them with a single registered carry and
// deserialises the result into a parallel WIDTH-bit sum plus carry-out.
//
// Configuration macro: SERIAL_ADD_SUB_EN
//   defined   -> 'sub' port present; sub sampled with start selects a-b
//                (computed as a + ~b + 1, carry=1 means no borrow)
//   undefined -> add only, initial carry always 0
//
// Ports:
//   clk       : input  rising-edge clock
//   rst_n     : input  asynchronous active-low reset
//   start     : input  begin new operation (wins over everything else)
//   sub       : input  subtract mode, sampled with start (SERIAL_ADD_SUB_EN)
//   bit_valid : input  a/b carry a valid bit pair
//   a, b      : input  operand bits, LSB first
//   bit_ready : output block accepts a bit pair this cycle
//   busy      : output high in SHIFT or DONE
//   sum       : output WIDTH-bit result, holds until next start
//   carry     : output carry-out, holds until next start
//   done      : output one-cycle pulse, result valid
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_add_rx
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic             bit_valid,
    input  logic             a,
    input  logic             b,
    output logic             bit_ready,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    serial_add_state_e state_r;
    logic [CW-1:0]     count_r;
    logic              cy_r;        // running carry between bit positions
    logic [WIDTH-1:0]  sum_r;
    logic              carry_r;     // published carry-out
    logic              done_r;
    logic              bit_ready_r;
    logic              busy_r;

    logic              b_eff_s;
    logic              fa_sum_s;
    logic              fa_cout_s;
    logic              accept_s;
    logic              last_bit_s;

`ifdef SERIAL_ADD_SUB_EN
    logic              sub_r;

    // Subtraction inverts B; the +1 comes from the carry preset at start
    assign b_eff_s = b ^ sub_r;
`else
    assign b_eff_s = b;
`endif

    // A bit pair is consumed only in SHIFT and never in the cycle start restarts
    assign accept_s   = bit_valid & bit_ready_r & (state_r == SHIFT) & ~start;
    assign last_bit_s = (count_r == CW'(WIDTH - 1));

    full_add_cell u_full_add_cell (
        .a    (a),
        .b    (b_eff_s),
        .cin  (cy_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // FSM, bit counter, carry flop and sum shift register with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= {CW{1'b0}};
            cy_r        <= 1'b0;
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            done_r      <= 1'b0;
            bit_ready_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_r       <= 1'b0;
`endif
        end else if (start) begin
            // Restart from any state; a concurrent bit pair is dropped
            state_r     <= SHIFT;
            count_r     <= {CW{1'b0}};
            sum_r       <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            done_r      <= 1'b0;
            bit_ready_r <= 1'b1;
            busy_r      <= 1'b1;
`ifdef SERIAL_ADD_SUB_EN
            sub_r       <= sub;
            cy_r        <= sub;
`else
            cy_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r      <= 1'b0;
                    bit_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                SHIFT: begin
                    if (accept_s) begin
                        // LSB arrives first, so shift right and insert at MSB
                        sum_r <= {fa_sum_s, sum_r[WIDTH-1:1]};
                        cy_r  <= fa_cout_s;
                        if (last_bit_s) begin
                            state_r     <= DONE;
                            carry_r     <= fa_cout_s;
                            done_r      <= 1'b1;
                            bit_ready_r <= 1'b0;
                        end else begin
                            count_r     <= count_r + CW'(32'd1);
                        end
                    end else begin
                        bit_ready_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    done_r      <= 1'b0;
                    bit_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    done_r      <= 1'b0;
                    bit_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bit_ready = bit_ready_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign carry     = carry_r;
    assign done      = done_r;

endmodule : serial_add_rx

// File: tb/tb_serial_add_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_add_rx
// Directed self-checking bench for serial_add_rx with WIDTH=8. Inputs change
// and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_add_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         bit_valid;
    logic         a;
    logic         b;
    logic         bit_ready;
    logic         busy;
    logic [W-1:0] sum;
    logic         carry;
    logic         done;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_add_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .bit_valid (bit_valid),
        .a         (a),
        .b         (b),
        .bit_ready (bit_ready),
        .busy      (busy),
        .sum       (sum),
        .carry     (carry),
        .done      (done)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge and confirm everything was cleared
    task automatic start_op(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_sum"},   32'(sum),       32'd0);
        check({tag, "_start_carry"}, 32'(carry),     32'd0);
        check({tag, "_start_ready"}, 32'(bit_ready), 32'd1);
        check({tag, "_start_busy"},  32'(busy),      32'd1);
        check({tag, "_start_done"},  32'(done),      32'd0);
    endtask

    // Full operation: start, WIDTH bit pairs (optionally with one idle cycle
    // between pairs), then check the result cycle and the cycle after
    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit gaps,
                         input logic [7:0] exp_sum, input logic exp_carry, input string tag);
        start_op(tag);
        for (int i = 0; i < W; i++) begin
            a         = x[i];
            b         = y[i];
            bit_valid = 1'b1;
            if (i == W - 1) begin
                check({tag, "_done_early"}, 32'(done), 32'd0);
            end
            tick();
            if (gaps && (i < W - 1)) begin
                bit_valid = 1'b0;
                a         = ~x[i];
                b         = ~y[i];
                tick();
            end
        end
        bit_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        check({tag, "_done"},      32'(done),      32'd1);
        check({tag, "_sum"},       32'(sum),       32'(exp_sum));
        check({tag, "_carry"},     32'(carry),     32'(exp_carry));
        check({tag, "_ready_end"}, 32'(bit_ready), 32'd0);
        check({tag, "_busy_end"},  32'(busy),      32'd1);
        tick();
        check({tag, "_done_pulse"}, 32'(done),  32'd0);
        check({tag, "_busy_idle"},  32'(busy),  32'd0);
        check({tag, "_sum_hold"},   32'(sum),   32'(exp_sum));
        check({tag, "_carry_hold"}, 32'(carry), 32'(exp_carry));
    endtask

    // Feed n identical bit pairs back to back without finishing the operation
    task automatic partial_bits(input int n, input logic av, input logic bv);
        for (int i = 0; i < n; i++) begin
            a         = av;
            b         = bv;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub       = 1'b0;
`endif
        repeat (3) tick();
        check("rst_sum",   32'(sum),       32'd0);
        check("rst_carry", 32'(carry),     32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_ready", 32'(bit_ready), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(bit_ready), 32'd0);

        // Continuous bits: done in cycle 9
        do_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "add_35_4a");

        // Overflow wraps modulo 256, reported via carry
        do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");

        // bit_valid in IDLE is ignored; result holds
        partial_bits(3, 1'b1, 1'b1);
        check("idle_ign_sum",   32'(sum),       32'd0);
        check("idle_ign_carry", 32'(carry),     32'd1);
        check("idle_ign_ready", 32'(bit_ready), 32'd0);
        check("idle_ign_busy",  32'(busy),      32'd0);

        // bit_valid every other cycle: done at cycle 16 after start
        do_op(8'h0F, 8'h01, 1'b1, 8'h10, 1'b0, "add_gap");

        // Restart after 3 bits: earlier bits must not leak into the new result
        start_op("abort");
        partial_bits(3, 1'b1, 1'b1);
        check("abort_busy", 32'(busy), 32'd1);
        do_op(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "add_02_03");

        // Asynchronous reset mid-operation
        start_op("rst_mid");
        partial_bits(4, 1'b1, 1'b0);
        check("rst_mid_partial", 32'(sum), 32'hF0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_sum",   32'(sum),       32'd0);
        check("rst_mid_carry", 32'(carry),     32'd0);
        check("rst_mid_done",  32'(done),      32'd0);
        check("rst_mid_ready", 32'(bit_ready), 32'd0);
        check("rst_mid_busy",  32'(busy),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, "add_aa_55");

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b1, "sub_10_01");
        do_op(8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, "sub_01_02");
        sub = 1'b0;
        do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "add_after_sub");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_serial_add_rx

// File: doc/serial_add_rx.md
# serial_add_rx

Bit-serial adder receive end: accepts operand bit pairs LSB-first over a valid/ready handshake, adds them with a single registered carry, and deserialises the result into a parallel WIDTH-bit sum plus carry-out. It sits as the consumer of a serial operand stream and is the sequential counterpart to the team's half-adder primitives. Datapath per bit is one full-adder cell built from two half adders.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin new operation; clears accumulator and counter
- sub  input  1  subtract mode, sampled with start (only when SERIAL_ADD_SUB_EN)
- bit_valid  input  1  a/b carry a valid bit pair
- a  input  1  operand A bit, LSB first
- b  input  1  operand B bit, LSB first
- bit_ready  output  1  block accepts a bit pair this cycle
- busy  output  1  high in SHIFT or DONE
- sum  output  WIDTH  result, holds until next start
- carry  output  1  carry-out (no-borrow in subtract mode), holds until next start
- done  output  1  one-cycle pulse, result valid

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: bit_ready=0, busy=0. start → SHIFT; count←0; carry register←0 (1 if subtracting); sum←0.
- SHIFT: bit_ready=1. Accept when bit_valid & bit_ready: s=a^b'^c, c←majority(a,b',c), b'=b (or ~b when subtracting); sum←{s, sum[WIDTH-1:1]} (shift right, MSB insert); count++.
- Accept with count==WIDTH-1 → DONE; carry output←new c.
- DONE: done=1, bit_ready=0 → IDLE next cycle.
- start in any state restarts (→ SHIFT, all cleared). start with bit_valid in SHIFT: start wins, bit dropped. start in DONE: done still pulses that cycle.
- bit_valid outside SHIFT ignored; no backpressure other than bit_ready=0.
- Arithmetic is modulo 2^WIDTH; overflow reported only via carry.
- Counter width $clog2(WIDTH); no wrap beyond WIDTH-1.

## Timing
- Reset (async assert, sync deassert by clk): state IDLE, sum=0, carry=0, done=0, bit_ready=0, busy=0.
- start sampled at edge 0 → bit_ready high from cycle 1.
- Bits back-to-back: accepted cycles 1..WIDTH; done high in cycle WIDTH+1, sum/carry final in the same cycle.
- Gaps in bit_valid stretch SHIFT by one cycle per idle cycle; no timeout.
- Reset mid-operation: immediate return to reset values; partial result discarded.
- All outputs registered.

## Configuration
- SERIAL_ADD_SUB_EN defined: sub port present; sub sampled at start; subtract computes a−b as a+~b+1; carry=1 means no borrow.
- Undefined: sub port absent; add only; initial carry always 0.

## Structure
- Package serial_add_pkg: state enum (IDLE, SHIFT, DONE), default WIDTH constant.
- Sub-module full_add_cell (a, b, cin → s, cout), two half-adder stages plus OR; instantiated once in the datapath.
- Top holds FSM, counter, carry flop, sum shift register.

## Test plan
- WIDTH=8, 0x35+0x4A, bits continuous → done at cycle 9, sum=0x7F, carry=0.
- 0xFF+0x01 → sum=0x00, carry=1; done exactly one cycle.
- 0x0F+0x01 with bit_valid toggling every other cycle → sum=0x10, carry=0, done at cycle 16 after start.
- start mid-operation after 3 bits, then 0x02+0x03 → sum=0x05; earlier bits have no effect.
- rst_n low after 4 bits → all outputs 0 immediately, bit_ready=0; next op 0xAA+0x55 → sum=0xFF, carry=0.
- SERIAL_ADD_SUB_EN, sub=1: 0x10−0x01 → sum=0x0F, carry=1; 0x01−0x02 → sum=0xFF, carry=0.
